keypad_scanner: RTL and testbench

- Reads a 4x4 matrix keypad, the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one row low at a time and samples the active-low columns.
- Debounces across full scans.
- Emits a hex key code plus a one-cycle strobe, suitable for feeding the segment display digit inputs.
- Sits in the board top level beside the display instances, clocked by the 100 MHz system clock.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_scanner_scan_tick.sv | 28 ++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 tb/tb_keypad_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Also holds the row/column to hex key-code map.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Classification of one complete four-row scan.
  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_res_t;

  // Debounce FSM states, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Physical key position to hex code; row 3 is the "*0#D" row.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Row-step enable generator: one-cycle tick every SCAN_DIV clocks.
module scan_tick #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces whole
// scans, and reports an accepted key as a hex code with a one-cycle strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_down
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] DB_MAX = SW'(DEBOUNCE_SCANS);

  logic [COLS-1:0]      col_meta;
  logic [COLS-1:0]      col_sync;
  logic                 tick;
  logic                 scan_end;
  logic [1:0]           row_idx;
  logic [ROWS*COLS-1:0] acc;
  logic [ROWS*COLS-1:0] acc_next;
  logic [4:0]           ones;
  logic [3:0]           hit_idx;
  scan_res_t            res;
  scan_res_t            prev_res;
  logic [3:0]           code;
  logic [3:0]           prev_code;
  logic [SW-1:0]        stable;
  logic [SW-1:0]        stable_next;
  logic [0:0]           state;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst_ (rst_),
    .tick (tick)
  );

  // Columns are asynchronous to clk; reset to the idle (pulled-up) level.
  always_ff @(posedge clk) begin
    if (rst_) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  assign row_n    = ~(4'b0001 << row_idx);
  assign scan_end = tick && (row_idx == 2'd3);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_next = acc;
    acc_next[{row_idx, 2'b00} +: COLS] = ~col_sync;
  end

  // Count pressed positions and remember the last one; only meaningful when exactly one is set.
  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (acc_next[i]) begin
        ones    = ones + 1'b1;
        hit_idx = 4'(i);
      end
    end
    if (ones == 5'd0) begin
      res = RES_NONE;
    end else if (ones == 5'd1) begin
      res = RES_KEY;
    end else begin
      res = RES_MULTI;
    end
    code = (res == RES_KEY) ? key_map(hit_idx[3:2], hit_idx[1:0]) : 4'h0;
  end

  // Non-KEY results carry code 0, so {res, code} equality covers "same key".
  always_comb begin
    if (res == prev_res && code == prev_code) begin
      stable_next = (stable == DB_MAX) ? stable : stable + 1'b1;
    end else begin
      stable_next = SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      row_idx   <= '0;
      acc       <= '0;
      prev_res  <= RES_NONE;
      prev_code <= '0;
      stable    <= '0;
      state     <= ST_IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        if (scan_end) begin
          acc       <= '0;
          prev_res  <= res;
          prev_code <= code;
          stable    <= stable_next;
          if (state == ST_IDLE) begin
            if (res == RES_KEY && stable_next == DB_MAX) begin
              key_code  <= code;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              state     <= ST_HELD;
            end
          end else begin
            // Other keys and ghosting are ignored until a clean release.
            if (res == RES_NONE && stable_next == DB_MAX) begin
              key_down <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;
  int base;
  logic [3:0] last_code = 4'h0;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Key matrix: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_code = key_code;
      check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = key_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int budget, input string tag);
    int start = pulse_cnt;
    int n = 0;
    while (pulse_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, pulse_cnt - start, 32'd1);
  endtask

  initial begin
    pressed = '0;
    rst_    = 1'b1;

    // 1: reset values and row rotation timing
    cycles(3);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    check("rst_code", key_code, 4'h0);
    rst_ = 1'b0;
    cycles(3);
    check("row0_held", row_n, 4'b1110);
    cycles(1);
    check("row1_at_4", row_n, 4'b1101);
    cycles(4);
    check("row2_at_8", row_n, 4'b1011);
    cycles(4);
    check("row3_at_12", row_n, 4'b0111);
    cycles(4);
    check("row0_at_16", row_n, 4'b1110);

    // 2: clean press of key 5 (r1,c1)
    base = pulse_cnt;
    pressed[5] = 1'b1;
    wait_pulse(3*16+2, "t2_pulse");
    check("t2_code", last_code, 4'h5);
    check("t2_down", key_down, 1'b1);
    cycles(64);
    check("t2_no_repeat", pulse_cnt - base, 32'd1);
    check("t2_still_down", key_down, 1'b1);

    // 5: a one-scan release is rejected, a two-scan release is accepted
    base = pulse_cnt;
    pressed[5] = 1'b0;
    cycles(16);
    pressed[5] = 1'b1;
    cycles(48);
    check("t5_short_rel_down", key_down, 1'b1);
    check("t5_short_rel_pulse", pulse_cnt - base, 32'd0);
    pressed[5] = 1'b0;
    cycles(16);
    check("t5_rel_1scan", key_down, 1'b1);
    cycles(16);
    check("t5_rel_2scan", key_down, 1'b0);
    pressed[14] = 1'b1;
    wait_pulse(3*16+2, "t5_pulse_f");
    check("t5_code_f", last_code, 4'hF);
    check("t5_key_code_f", key_code, 4'hF);

    // 3: bouncing '*' key (r3,c0) never settles
    pressed = '0;
    cycles(48);
    check("t3_idle", key_down, 1'b0);
    base = pulse_cnt;
    for (int s = 0; s < 8; s++) begin
      pressed[12] = (s % 2 == 0);
      cycles(16);
    end
    pressed = '0;
    check("t3_no_pulse", pulse_cnt - base, 32'd0);
    check("t3_down", key_down, 1'b0);

    // 4: two keys in one row read as ghosting, then a single key is accepted
    base = pulse_cnt;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    cycles(80);
    check("t4_multi_no_pulse", pulse_cnt - base, 32'd0);
    check("t4_multi_down", key_down, 1'b0);
    pressed[1] = 1'b0;
    wait_pulse(3*16+2, "t4_pulse");
    check("t4_code", last_code, 4'h1);

    // 6a: reset while HELD; the still-pressed key must requalify over two scans
    base = pulse_cnt;
    cycles(5);
    rst_ = 1'b1;
    cycles(2);
    check("t6_held_rst_down", key_down, 1'b0);
    check("t6_held_rst_row", row_n, 4'b1110);
    check("t6_held_rst_code", key_code, 4'h0);
    check("t6_held_rst_valid", key_valid, 1'b0);
    rst_ = 1'b0;
    cycles(16);
    check("t6_one_scan_no_pulse", pulse_cnt - base, 32'd0);
    check("t6_one_scan_down", key_down, 1'b0);
    cycles(15);
    check("t6_before_second_end", pulse_cnt - base, 32'd0);
    cycles(1);
    check("t6_second_end_pulse", pulse_cnt - base, 32'd1);
    check("t6_code", last_code, 4'h1);
    check("t6_down", key_down, 1'b1);

    // 6b: reset in the middle of a debounce
    pressed = '0;
    cycles(48);
    check("t6b_idle", key_down, 1'b0);
    base = pulse_cnt;
    pressed[5] = 1'b1;
    cycles(20);
    rst_ = 1'b1;
    cycles(2);
    check("t6b_rst_row", row_n, 4'b1110);
    check("t6b_rst_down", key_down, 1'b0);
    rst_ = 1'b0;
    cycles(31);
    check("t6b_no_early_pulse", pulse_cnt - base, 32'd0);
    cycles(1);
    check("t6b_pulse", pulse_cnt - base, 32'd1);
    check("t6b_code", last_code, 4'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
